// File: rtl/elevator_request_scheduler.sv
// SCAN (collective) elevator call scheduler: latches floor calls, picks the next
// target in the current sweep direction, drives the controller and holds a door dwell.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS   = 16,
    parameter int FLOOR_W      = 4,
    parameter int DWELL_CYCLES = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NUM_FLOORS-1:0] call_req_i,
    input  logic [FLOOR_W-1:0]    cur_floor_i,
    input  logic                  arrived_i,
    input  logic                  blocked_i,
    output logic [FLOOR_W-1:0]    target_floor_o,
    output logic                  target_valid_o,
    output logic                  dir_up_o,
    output logic                  door_open_cmd_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  busy_o,
    output logic [1:0]            state_o
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_MOVE   = 2'd2;
    localparam logic [1:0] ST_DWELL  = 2'd3;
    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic                  dir_up_q, dir_up_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [NUM_FLOORS-1:0] cur_onehot, tgt_onehot, call_eff, merged, clr;
    logic                  cur_pending;
    logic                  above_found, below_found, rt_found;
    logic [FLOOR_W-1:0]    above_floor, below_floor, rt_floor;

    // A cur_floor outside the served range matches no bit, so it never counts as pending.
    always_comb begin : decode
        cur_onehot = '0;
        tgt_onehot = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cur_onehot[i] = (cur_floor_i == FLOOR_W'(i));
            tgt_onehot[i] = (target_q == FLOOR_W'(i));
        end
        cur_pending = |(pending_q & cur_onehot);
        call_eff    = call_req_i & ~((state_q == ST_DWELL) ? cur_onehot : '0);
        merged      = pending_q | call_eff;
    end

    always_comb begin : search
        above_found = 1'b0;
        above_floor = '0;
        below_found = 1'b0;
        below_floor = '0;
        rt_found    = 1'b0;
        rt_floor    = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (FLOOR_W'(i) > cur_floor_i)) begin
                above_found = 1'b1;
                above_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (FLOOR_W'(i) < cur_floor_i)) begin
                below_found = 1'b1;
                below_floor = FLOOR_W'(i);
            end
        end
        // Nearest fresh call strictly between the car and its target wins the re-target.
        if (dir_up_q) begin
            for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
                if (call_req_i[i] && (FLOOR_W'(i) > cur_floor_i) && (FLOOR_W'(i) < target_q)) begin
                    rt_found = 1'b1;
                    rt_floor = FLOOR_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (call_req_i[i] && (FLOOR_W'(i) < cur_floor_i) && (FLOOR_W'(i) > target_q)) begin
                    rt_found = 1'b1;
                    rt_floor = FLOOR_W'(i);
                end
            end
        end
    end

    always_comb begin : fsm
        state_d  = state_q;
        target_d = target_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        clr      = '0;
        case (state_q)
            ST_IDLE: begin
                if (!blocked_i) begin
                    if (cur_pending) begin
                        state_d  = ST_DWELL;
                        target_d = cur_floor_i;
                        clr      = cur_onehot;
                        cnt_d    = '0;
                    end else if (|pending_q) begin
                        state_d = ST_SELECT;
                    end
                end
            end
            ST_SELECT: begin
                if (cur_pending) begin
                    state_d  = ST_DWELL;
                    target_d = cur_floor_i;
                    clr      = cur_onehot;
                    cnt_d    = '0;
                end else if (dir_up_q) begin
                    if (above_found) begin
                        state_d  = ST_MOVE;
                        target_d = above_floor;
                    end else if (below_found) begin
                        state_d  = ST_MOVE;
                        target_d = below_floor;
                        dir_up_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (below_found) begin
                        state_d  = ST_MOVE;
                        target_d = below_floor;
                    end else if (above_found) begin
                        state_d  = ST_MOVE;
                        target_d = above_floor;
                        dir_up_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_MOVE: begin
                if (!blocked_i) begin
                    if (arrived_i && (cur_floor_i == target_q)) begin
                        state_d = ST_DWELL;
                        clr     = tgt_onehot;
                        cnt_d   = '0;
                    end else if (rt_found) begin
                        target_d = rt_floor;
                    end
                end
            end
            default: begin
                if (!blocked_i) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = (|merged) ? ST_SELECT : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    assign pending_d = merged & ~clr;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            target_q  <= '0;
            dir_up_q  <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            dir_up_q  <= dir_up_d;
            cnt_q     <= cnt_d;
        end
    end

    assign target_floor_o  = target_q;
    assign target_valid_o  = (state_q == ST_MOVE);
    assign dir_up_o        = dir_up_q;
    assign door_open_cmd_o = (state_q == ST_DWELL);
    assign pending_o       = pending_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign state_o         = state_q;
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: vector table, directed corner sequences and
// random traffic against a floor-walking reference model of the SCAN rules.
module tb_elevator_request_scheduler;
    localparam int N  = 16;
    localparam int FW = 4;
    localparam int D  = 5;
    localparam int M_IDLE = 0, M_SELECT = 1, M_MOVE = 2, M_DWELL = 3;

    // Clock and reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]  call_req;
    logic [FW-1:0] cur_floor;
    logic          arrived, blocked;
    logic [FW-1:0] target_floor;
    logic          target_valid, dir_up, door_open, busy;
    logic [N-1:0]  pending;
    logic [1:0]    state_dbg;

    elevator_request_scheduler #(.NUM_FLOORS(N), .FLOOR_W(FW), .DWELL_CYCLES(D)) dut (
        .clk_i(clk), .reset_i(reset), .call_req_i(call_req), .cur_floor_i(cur_floor),
        .arrived_i(arrived), .blocked_i(blocked), .target_floor_o(target_floor),
        .target_valid_o(target_valid), .dir_up_o(dir_up), .door_open_cmd_o(door_open),
        .pending_o(pending), .busy_o(busy), .state_o(state_dbg)
    );

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: call set, target, direction and dwell cycles still owed
    int m_mode;
    bit m_pend[N];
    int m_tf;
    bit m_dir;
    int m_left;

    task automatic model_step();
        bit nxt[N];
        bit any_new;
        int c, above, below, old_tf;
        bit found;
        c = int'(cur_floor);
        if (reset) begin
            m_mode = M_IDLE;
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_tf = 0;
            m_dir = 1'b1;
            m_left = 0;
            return;
        end
        for (int i = 0; i < N; i++)
            nxt[i] = m_pend[i] | (call_req[i] && !(m_mode == M_DWELL && i == c));
        case (m_mode)
            M_IDLE: begin
                if (!blocked) begin
                    if (c < N && m_pend[c]) begin
                        m_mode = M_DWELL; m_tf = c; nxt[c] = 1'b0; m_left = D;
                    end else begin
                        for (int i = 0; i < N; i++) if (m_pend[i]) m_mode = M_SELECT;
                    end
                end
            end
            M_SELECT: begin
                if (c < N && m_pend[c]) begin
                    m_mode = M_DWELL; m_tf = c; nxt[c] = 1'b0; m_left = D;
                end else begin
                    above = -1;
                    below = -1;
                    for (int d = 1; d <= N; d++) begin
                        if (above < 0 && c + d < N && m_pend[c + d]) above = c + d;
                        if (below < 0 && c - d >= 0 && c - d < N && m_pend[c - d]) below = c - d;
                    end
                    m_mode = M_MOVE;
                    if (m_dir && above >= 0) m_tf = above;
                    else if (m_dir && below >= 0) begin m_tf = below; m_dir = 1'b0; end
                    else if (!m_dir && below >= 0) m_tf = below;
                    else if (!m_dir && above >= 0) begin m_tf = above; m_dir = 1'b1; end
                    else m_mode = M_IDLE;
                end
            end
            M_MOVE: begin
                if (!blocked) begin
                    if (arrived && c == m_tf) begin
                        m_mode = M_DWELL; nxt[c] = 1'b0; m_left = D;
                    end else begin
                        old_tf = m_tf;
                        found = 1'b0;
                        if (m_dir) begin
                            for (int p = c + 1; p < old_tf; p++)
                                if (!found && call_req[p]) begin found = 1'b1; m_tf = p; end
                        end else begin
                            for (int p = c - 1; p > old_tf; p--)
                                if (!found && call_req[p]) begin found = 1'b1; m_tf = p; end
                        end
                    end
                end
            end
            default: begin
                if (!blocked) begin
                    m_left--;
                    if (m_left == 0) begin
                        any_new = 1'b0;
                        for (int i = 0; i < N; i++) any_new |= nxt[i];
                        m_mode = any_new ? M_SELECT : M_IDLE;
                    end
                end
            end
        endcase
        for (int i = 0; i < N; i++) m_pend[i] = nxt[i];
    endtask

    task automatic compare_model();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = m_pend[i];
        check("model_tv", target_valid, m_mode == M_MOVE);
        check("model_door", door_open, m_mode == M_DWELL);
        check("model_busy", busy, m_mode != M_IDLE);
        check("model_tf", target_floor, m_tf);
        check("model_dir", dir_up, m_dir);
        check("model_pend", pending, p);
    endtask

    // Driver: inputs were set away from the edge; advance one cycle and sample at +1
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic serve_next(input string tag, input bit exp_dir);
        int n;
        logic [FW-1:0] want;
        want = exp_q.pop_front();
        n = 0;
        while (!target_valid && n < 20) begin step(); n++; end
        check({tag, "_wait_tv"}, target_valid, 1);
        check({tag, "_tf"}, target_floor, want);
        check({tag, "_dir"}, dir_up, exp_dir);
        cur_floor = want;
        arrived = 1'b1;
        step();
        arrived = 1'b0;
        check({tag, "_door_on"}, door_open, 1);
        n = 0;
        while (door_open && n < 20) begin step(); n++; end
        check({tag, "_door_off"}, door_open, 0);
    endtask

    typedef struct {
        logic [N-1:0]  call;
        logic [FW-1:0] cur;
        logic          arr;
        logic          blk;
        logic          tv;
        logic [FW-1:0] tf;
        logic          dir;
        logic          door;
        logic [N-1:0]  pend;
        logic          busy;
    } vec_t;
    vec_t vecs[17];

    function automatic vec_t mk(input logic [N-1:0] call, input int cur, input logic arr,
                                input logic blk, input logic tv, input int tf, input logic dir,
                                input logic door, input logic [N-1:0] pend, input logic bsy);
        vec_t v;
        v.call = call; v.cur = FW'(cur); v.arr = arr; v.blk = blk; v.tv = tv;
        v.tf = FW'(tf); v.dir = dir; v.door = door; v.pend = pend; v.busy = bsy;
        return v;
    endfunction

    initial begin
        int ub, n;
        // Call to 5 from floor 0, travel, arrive, five-cycle dwell
        vecs[0]  = mk(16'h0020, 0, 0, 0, 0, 0, 1, 0, 16'h0020, 0);
        vecs[1]  = mk(16'h0000, 0, 0, 0, 0, 0, 1, 0, 16'h0020, 1);
        vecs[2]  = mk(16'h0000, 0, 0, 0, 1, 5, 1, 0, 16'h0020, 1);
        vecs[3]  = mk(16'h0000, 3, 0, 0, 1, 5, 1, 0, 16'h0020, 1);
        vecs[4]  = mk(16'h0000, 5, 1, 0, 0, 5, 1, 1, 16'h0000, 1);
        vecs[5]  = mk(16'h0000, 5, 0, 0, 0, 5, 1, 1, 16'h0000, 1);
        vecs[6]  = mk(16'h0000, 5, 0, 0, 0, 5, 1, 1, 16'h0000, 1);
        vecs[7]  = mk(16'h0000, 5, 0, 0, 0, 5, 1, 1, 16'h0000, 1);
        vecs[8]  = mk(16'h0000, 5, 0, 0, 0, 5, 1, 1, 16'h0000, 1);
        vecs[9]  = mk(16'h0000, 5, 0, 0, 0, 5, 1, 0, 16'h0000, 0);
        // Call at the car's own floor: direct dwell, repeat call absorbed
        vecs[10] = mk(16'h0010, 4, 0, 0, 0, 5, 1, 0, 16'h0010, 0);
        vecs[11] = mk(16'h0000, 4, 0, 0, 0, 4, 1, 1, 16'h0000, 1);
        vecs[12] = mk(16'h0010, 4, 0, 0, 0, 4, 1, 1, 16'h0000, 1);
        vecs[13] = mk(16'h0000, 4, 0, 0, 0, 4, 1, 1, 16'h0000, 1);
        vecs[14] = mk(16'h0000, 4, 0, 0, 0, 4, 1, 1, 16'h0000, 1);
        vecs[15] = mk(16'h0000, 4, 0, 0, 0, 4, 1, 1, 16'h0000, 1);
        vecs[16] = mk(16'h0000, 4, 0, 0, 0, 4, 1, 0, 16'h0000, 0);

        reset = 1'b1; call_req = '0; cur_floor = '0; arrived = 1'b0; blocked = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_tv", target_valid, 0);
        check("rst_tf", target_floor, 0);
        check("rst_dir", dir_up, 1);
        check("rst_door", door_open, 0);
        check("rst_pend", pending, 0);
        check("rst_busy", busy, 0);

        for (int k = 0; k < 17; k++) begin
            call_req = vecs[k].call; cur_floor = vecs[k].cur;
            arrived = vecs[k].arr; blocked = vecs[k].blk;
            step();
            check($sformatf("v%0d_tv", k), target_valid, vecs[k].tv);
            check($sformatf("v%0d_tf", k), target_floor, vecs[k].tf);
            check($sformatf("v%0d_dir", k), dir_up, vecs[k].dir);
            check($sformatf("v%0d_door", k), door_open, vecs[k].door);
            check($sformatf("v%0d_pend", k), pending, vecs[k].pend);
            check($sformatf("v%0d_busy", k), busy, vecs[k].busy);
        end
        call_req = '0; arrived = 1'b0; blocked = 1'b0;

        // Sweep order from floor 3 going up: 6, 9, then reverse to 1
        cur_floor = 4'd3;
        call_req = 16'h0242;
        step();
        call_req = '0;
        exp_q.push_back(4'd6); exp_q.push_back(4'd9); exp_q.push_back(4'd1);
        serve_next("scan6", 1'b1);
        serve_next("scan9", 1'b1);
        serve_next("scan1", 1'b0);

        // Re-target 2->8 to a call at 5 while passing floor 3
        cur_floor = 4'd2;
        call_req = 16'h0100;
        step();
        call_req = '0;
        step();
        step();
        check("rt_tv", target_valid, 1);
        check("rt_tf8", target_floor, 8);
        check("rt_dir", dir_up, 1);
        cur_floor = 4'd3;
        step();
        call_req = 16'h0020;
        step();
        call_req = '0;
        check("rt_tf5", target_floor, 5);
        check("rt_pend", pending, 16'h0120);
        exp_q.push_back(4'd5); exp_q.push_back(4'd8);
        serve_next("rt5", 1'b1);
        serve_next("rt8", 1'b1);

        // Blocked during move holds the target; blocked during dwell freezes the count
        call_req = 16'h1000;
        step();
        call_req = '0;
        step();
        step();
        check("blk_move_tv", target_valid, 1);
        blocked = 1'b1;
        step();
        step();
        check("blk_hold_tv", target_valid, 1);
        check("blk_hold_tf", target_floor, 12);
        blocked = 1'b0;
        cur_floor = 4'd12;
        arrived = 1'b1;
        step();
        arrived = 1'b0;
        check("blk_dwell_on", door_open, 1);
        ub = 0;
        step(); ub++;
        step(); ub++;
        blocked = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("blk_dwell_frozen", door_open, 1);
        end
        blocked = 1'b0;
        n = 0;
        while (door_open && n < 20) begin step(); ub++; n++; end
        check("blk_dwell_unblocked_cycles", ub, D);

        // Reset mid-move discards everything
        cur_floor = 4'd5;
        call_req = 16'h0084;
        step();
        call_req = '0;
        step();
        step();
        check("rm_tv", target_valid, 1);
        check("rm_tf", target_floor, 7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rm_tv0", target_valid, 0);
        check("rm_tf0", target_floor, 0);
        check("rm_dir", dir_up, 1);
        check("rm_door", door_open, 0);
        check("rm_pend", pending, 0);
        check("rm_busy", busy, 0);
        check("rm_state", state_dbg, 0);

        // Random traffic with a car that walks toward its target
        for (int k = 0; k < 3000; k++) begin
            call_req = ($urandom_range(0, 5) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
            blocked = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 499) == 0);
            if (target_valid && cur_floor != target_floor && $urandom_range(0, 1) == 1)
                cur_floor = (cur_floor < target_floor) ? cur_floor + FW'(1) : cur_floor - FW'(1);
            arrived = target_valid && (cur_floor == target_floor);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
